// File: rtl/nco_sweep_controller.sv
// Linear frequency-sweep controller driving an NCO tuning word.
// Free-running CE prescaler plus IDLE/RUN/FLUSH sweep sequencer.
module nco_sweep_controller #(
    parameter int unsigned PHASE_WIDTH = 64,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    output logic                   sample_clk_ce,
    output logic [PHASE_WIDTH-1:0] phase_increment,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_WIDTH-1:0]   presc_cnt;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic                   ce_hit;

    logic                   cont_q;
    logic [PHASE_WIDTH-1:0] start_q;
    logic [PHASE_WIDTH-1:0] stop_q;
    logic [PHASE_WIDTH-1:0] step_q;
    logic [DWELL_WIDTH-1:0] dwell_q;

    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_last;
    logic [1:0]             flush_cnt;

    logic [PHASE_WIDTH:0]   next_sum;
    logic                   past_stop;
    logic                   step_ev;
    logic                   flush_last;

    // The divider is captured at the start of each period (counter at 0),
    // so a mid-period change only shapes the following period.
    assign div_eff = (presc_cnt == '0) ? cfg_div : div_q;
    assign ce_hit  = (presc_cnt == div_eff);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            presc_cnt     <= '0;
            div_q         <= '0;
            sample_clk_ce <= 1'b0;
        end else begin
            sample_clk_ce <= ce_hit;
            if (presc_cnt == '0) begin
                div_q <= cfg_div;
            end
            if (ce_hit) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + DIV_WIDTH'(1);
            end
        end
    end

    // One extra bit keeps an overflowing sum from wrapping below stop.
    assign next_sum   = {1'b0, phase_increment} + {1'b0, step_q};
    assign past_stop  = (next_sum >= {1'b0, stop_q});
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
    assign step_ev    = sample_clk_ce && (dwell_cnt == dwell_last);
    assign flush_last = sample_clk_ce && (flush_cnt == 2'd2);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (step_ev && past_stop && !cont_q) begin
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FLUSH) && flush_last && !abort;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            phase_increment <= '0;
            dwell_cnt       <= '0;
            flush_cnt       <= '0;
            cont_q          <= 1'b0;
            start_q         <= '0;
            stop_q          <= '0;
            step_q          <= '0;
            dwell_q         <= '0;
        end else if (abort) begin
            phase_increment <= '0;
            dwell_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cont_q          <= continuous;
                        start_q         <= cfg_start_inc;
                        stop_q          <= cfg_stop_inc;
                        step_q          <= cfg_step;
                        dwell_q         <= cfg_dwell;
                        phase_increment <= cfg_start_inc;
                        dwell_cnt       <= '0;
                        flush_cnt       <= '0;
                    end
                end
                RUN: begin
                    if (step_ev) begin
                        dwell_cnt <= '0;
                        if (!past_stop) begin
                            phase_increment <= next_sum[PHASE_WIDTH-1:0];
                        end else if (cont_q) begin
                            phase_increment <= start_q;
                        end else begin
                            phase_increment <= stop_q;
                            flush_cnt       <= '0;
                        end
                    end else if (sample_clk_ce) begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    if (flush_last) begin
                        flush_cnt <= '0;
                    end else if (sample_clk_ce) begin
                        flush_cnt <= flush_cnt + 2'd1;
                    end
                end
                default: begin
                    dwell_cnt <= '0;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed bench for nco_sweep_controller: prescaler timing,
// table-driven sweep vectors, and reset/abort corner cases.
module tb_nco_sweep_controller;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [63:0] cfg_start_inc;
    logic [63:0] cfg_stop_inc;
    logic [63:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [15:0] cfg_div;
    logic        sample_clk_ce;
    logic [63:0] phase_increment;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        st;
        logic        ab;
        logic        co;
        logic [63:0] s_inc;
        logic [63:0] e_inc;
        logic [63:0] stp;
        logic [15:0] dw;
        logic [63:0] pi;
        logic        bz;
        logic        dn;
    } vec_t;

    vec_t vq[$];

    logic [63:0] cur_s;
    logic [63:0] cur_e;
    logic [63:0] cur_stp;
    logic [15:0] cur_dw;

    nco_sweep_controller dut (
        .clk             (clk),
        .arst            (arst),
        .start           (start),
        .abort           (abort),
        .continuous      (continuous),
        .cfg_start_inc   (cfg_start_inc),
        .cfg_stop_inc    (cfg_stop_inc),
        .cfg_step        (cfg_step),
        .cfg_dwell       (cfg_dwell),
        .cfg_div         (cfg_div),
        .sample_clk_ce   (sample_clk_ce),
        .phase_increment (phase_increment),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void cfg(input logic [63:0] s, input logic [63:0] e,
                                input logic [63:0] stp, input logic [15:0] dw);
        cur_s   = s;
        cur_e   = e;
        cur_stp = stp;
        cur_dw  = dw;
    endfunction

    function automatic void add(input logic st, input logic ab,
                                input logic co, input logic [63:0] pi,
                                input logic bz, input logic dn);
        vec_t v;
        v.st    = st;
        v.ab    = ab;
        v.co    = co;
        v.s_inc = cur_s;
        v.e_inc = cur_e;
        v.stp   = cur_stp;
        v.dw    = cur_dw;
        v.pi    = pi;
        v.bz    = bz;
        v.dn    = dn;
        vq.push_back(v);
    endfunction

    function automatic void build_table();
        logic [63:0] m5;
        logic [63:0] m1;
        m5 = 64'hFFFF_FFFF_FFFF_FFFB;
        m1 = 64'hFFFF_FFFF_FFFF_FFFF;
        // single sweep 100..130 step 10 dwell 2
        cfg(100, 130, 10, 2);
        add(1, 0, 0, 100, 1, 0);
        add(0, 0, 0, 100, 1, 0);
        add(0, 0, 0, 110, 1, 0);
        add(0, 0, 0, 110, 1, 0);
        add(0, 0, 0, 120, 1, 0);
        add(0, 0, 0, 120, 1, 0);
        add(0, 0, 0, 130, 1, 0);
        add(0, 0, 0, 130, 1, 0);
        add(0, 0, 0, 130, 1, 1);
        add(0, 0, 0, 130, 0, 0);
        add(0, 0, 0, 130, 0, 0);
        // continuous; restart with new cfg mid-run is ignored; abort
        add(1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 100, 1, 0);
        cfg(500, 900, 50, 1);
        add(1, 0, 0, 110, 1, 0);
        add(0, 0, 0, 110, 1, 0);
        add(0, 0, 0, 120, 1, 0);
        add(0, 0, 0, 120, 1, 0);
        add(0, 0, 0, 100, 1, 0);
        add(0, 0, 0, 100, 1, 0);
        add(0, 0, 0, 110, 1, 0);
        add(0, 1, 0, 0, 0, 0);
        cfg(100, 130, 10, 2);
        add(1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // dwell 0 acts as dwell 1
        cfg(100, 130, 10, 0);
        add(1, 0, 0, 100, 1, 0);
        add(0, 0, 0, 110, 1, 0);
        add(0, 0, 0, 120, 1, 0);
        add(0, 0, 0, 130, 1, 0);
        add(0, 0, 0, 130, 1, 0);
        add(0, 0, 0, 130, 1, 1);
        add(0, 0, 0, 130, 0, 0);
        // overflow of increment + step
        cfg(m5, m1, 10, 1);
        add(1, 0, 0, m5, 1, 0);
        add(0, 0, 0, m1, 1, 0);
        add(0, 0, 0, m1, 1, 0);
        add(0, 0, 0, m1, 1, 1);
        add(0, 0, 0, m1, 0, 0);
        // step 0 holds start until abort
        cfg(200, 300, 0, 1);
        add(1, 0, 0, 200, 1, 0);
        add(0, 0, 0, 200, 1, 0);
        add(0, 0, 0, 200, 1, 0);
        add(0, 0, 0, 200, 1, 0);
        add(0, 1, 0, 0, 0, 0);
        // start above stop: one dwell at start, then stop
        cfg(500, 400, 1, 3);
        add(1, 0, 0, 500, 1, 0);
        add(0, 0, 0, 500, 1, 0);
        add(0, 0, 0, 500, 1, 0);
        add(0, 0, 0, 400, 1, 0);
        add(0, 0, 0, 400, 1, 0);
        add(0, 0, 0, 400, 1, 1);
        add(0, 0, 0, 400, 0, 0);
    endfunction

    initial begin
        logic exp_ce;
        arst          = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        continuous    = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_div       = 16'd3;

        #23;
        chk("rst_ce", 64'(sample_clk_ce), 0);
        chk("rst_pi", phase_increment, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);

        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 8) exp_ce = (i % 4 == 3);
            else exp_ce = (i == 11) || (i > 11 && i % 2 == 1);
            chk($sformatf("ce_%0d", i), 64'(sample_clk_ce), 64'(exp_ce));
            if (i == 8) cfg_div = 16'd1;
            if (i == 17) cfg_div = 16'd0;
        end
        repeat (4) @(negedge clk);

        build_table();
        for (int i = 0; i < vq.size(); i++) begin
            start         = vq[i].st;
            abort         = vq[i].ab;
            continuous    = vq[i].co;
            cfg_start_inc = vq[i].s_inc;
            cfg_stop_inc  = vq[i].e_inc;
            cfg_step      = vq[i].stp;
            cfg_dwell     = vq[i].dw;
            @(negedge clk);
            chk($sformatf("v%0d_pi", i), phase_increment, vq[i].pi);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vq[i].bz));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(vq[i].dn));
        end
        start = 1'b0;
        abort = 1'b0;

        // reset while flushing
        continuous    = 1'b0;
        cfg_start_inc = 100;
        cfg_stop_inc  = 130;
        cfg_step      = 10;
        cfg_dwell     = 2;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("fl_pi", phase_increment, 130);
        chk("fl_busy", 64'(busy), 1);
        #2;
        arst = 1'b1;
        #1;
        chk("ar_pi", phase_increment, 0);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_done", 64'(done), 0);
        chk("ar_ce", 64'(sample_clk_ce), 0);
        repeat (2) begin
            @(negedge clk);
            chk("ar_hold_done", 64'(done), 0);
        end
        arst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_done", 64'(done), 0);
            chk("post_busy", 64'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
